// File: rtl/coo_row_scheduler.sv
// coo_row_scheduler: latches one COO tile, walks the row index through an external
// combinational row fetcher, and streams one registered row packet per row.
module coo_row_scheduler #(
   parameter int unsigned IN_SIZE    = 4,
   parameter int unsigned FETCH_SIZE = 2,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned SKIP_EMPTY = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [IN_SIZE-1:0][DATA_WIDTH-1:0]    in_data,
   input  logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    in_row_table,
   input  logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    in_col_table,
   input  logic [ADDR_WIDTH-1:0]                 in_num_rows,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [IN_SIZE-1:0][DATA_WIDTH-1:0]    fetch_data,
   output logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    fetch_row_table,
   output logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    fetch_col_table,
   output logic [ADDR_WIDTH-1:0]                 fetch_row_index,
   input  logic [FETCH_SIZE-1:0][DATA_WIDTH-1:0] fetched_data,
   input  logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] fetched_row_table,
   input  logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] fetched_col_table,
   output logic [FETCH_SIZE-1:0][DATA_WIDTH-1:0] out_data,
   output logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] out_row_table,
   output logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] out_col_table,
   output logic [ADDR_WIDTH-1:0]                 out_row_index,
   output logic [$clog2(FETCH_SIZE+1)-1:0]       out_nnz,
   output logic                                  out_overflow,
   output logic                                  out_last,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  busy
);

   localparam int unsigned CNT_WIDTH = $clog2(IN_SIZE + 1);
   localparam int unsigned NNZ_WIDTH = $clog2(FETCH_SIZE + 1);

   typedef enum logic [1:0] {StIdle, StFetch, StEmit} state_e;

   state_e state_q, state_d;

   logic [IN_SIZE-1:0][DATA_WIDTH-1:0]    tile_data_q, tile_data_d;
   logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    tile_row_q, tile_row_d;
   logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    tile_col_q, tile_col_d;
   logic [ADDR_WIDTH-1:0]                 num_rows_q, num_rows_d;
   logic [ADDR_WIDTH-1:0]                 row_cnt_q, row_cnt_d;

   logic [FETCH_SIZE-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] out_row_q, out_row_d;
   logic [FETCH_SIZE-1:0][ADDR_WIDTH-1:0] out_col_q, out_col_d;
   logic [ADDR_WIDTH-1:0]                 out_index_q, out_index_d;
   logic [NNZ_WIDTH-1:0]                  out_nnz_q, out_nnz_d;
   logic                                  out_overflow_q, out_overflow_d;
   logic                                  out_last_q, out_last_d;

   logic [CNT_WIDTH-1:0] match_cnt;
   logic                 is_last;
   logic                 overflow;
   logic [NNZ_WIDTH-1:0] clipped_nnz;

   // True nonzero count of the current row, independent of what the fetcher could keep.
   always_comb begin
      match_cnt = '0;
      for (int unsigned i = 0; i < IN_SIZE; i++) begin
         if (tile_row_q[i] == row_cnt_q) begin
            match_cnt = match_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // num_rows_q is never zero while fetching, so the subtraction cannot underflow here.
   assign is_last     = (row_cnt_q == num_rows_q - ADDR_WIDTH'(1));
   assign overflow    = (32'(match_cnt) > FETCH_SIZE);
   assign clipped_nnz = overflow ? NNZ_WIDTH'(FETCH_SIZE) : NNZ_WIDTH'(match_cnt);

   always_comb begin
      state_d        = state_q;
      tile_data_d    = tile_data_q;
      tile_row_d     = tile_row_q;
      tile_col_d     = tile_col_q;
      num_rows_d     = num_rows_q;
      row_cnt_d      = row_cnt_q;
      out_data_d     = out_data_q;
      out_row_d      = out_row_q;
      out_col_d      = out_col_q;
      out_index_d    = out_index_q;
      out_nnz_d      = out_nnz_q;
      out_overflow_d = out_overflow_q;
      out_last_d     = out_last_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               tile_data_d = in_data;
               tile_row_d  = in_row_table;
               tile_col_d  = in_col_table;
               num_rows_d  = in_num_rows;
               row_cnt_d   = '0;
               // An empty tile is consumed without leaving idle.
               if (in_num_rows != '0) begin
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            out_data_d     = fetched_data;
            out_row_d      = fetched_row_table;
            out_col_d      = fetched_col_table;
            out_index_d    = row_cnt_q;
            out_nnz_d      = clipped_nnz;
            out_overflow_d = overflow;
            out_last_d     = is_last;
            if ((SKIP_EMPTY != 0) && (match_cnt == '0) && !is_last) begin
               row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
            end else begin
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d = StIdle;
               end else begin
                  row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
                  state_d   = StFetch;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         tile_data_q    <= '0;
         tile_row_q     <= '0;
         tile_col_q     <= '0;
         num_rows_q     <= '0;
         row_cnt_q      <= '0;
         out_data_q     <= '0;
         out_row_q      <= '0;
         out_col_q      <= '0;
         out_index_q    <= '0;
         out_nnz_q      <= '0;
         out_overflow_q <= 1'b0;
         out_last_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         tile_data_q    <= tile_data_d;
         tile_row_q     <= tile_row_d;
         tile_col_q     <= tile_col_d;
         num_rows_q     <= num_rows_d;
         row_cnt_q      <= row_cnt_d;
         out_data_q     <= out_data_d;
         out_row_q      <= out_row_d;
         out_col_q      <= out_col_d;
         out_index_q    <= out_index_d;
         out_nnz_q      <= out_nnz_d;
         out_overflow_q <= out_overflow_d;
         out_last_q     <= out_last_d;
      end
   end

   assign in_ready        = (state_q == StIdle);
   assign out_valid       = (state_q == StEmit);
   assign busy            = (state_q != StIdle);

   assign fetch_data      = tile_data_q;
   assign fetch_row_table = tile_row_q;
   assign fetch_col_table = tile_col_q;
   assign fetch_row_index = row_cnt_q;

   assign out_data        = out_data_q;
   assign out_row_table   = out_row_q;
   assign out_col_table   = out_col_q;
   assign out_row_index   = out_index_q;
   assign out_nnz         = out_nnz_q;
   assign out_overflow    = out_overflow_q;
   assign out_last        = out_last_q;

endmodule

// File: tb/tb_coo_row_scheduler.sv
// Bench for coo_row_scheduler: two instances (SKIP_EMPTY 0 and 1) with a behavioural
// row fetcher each, scoreboards of expected row packets, and per-scenario tasks.
module tb_coo_row_scheduler;

   typedef logic [3:0][15:0] tab4_t;
   typedef logic [1:0][15:0] tab2_t;

   typedef struct packed {
      tab2_t       d;
      tab2_t       c;
      tab2_t       r;
      logic [15:0] idx;
      logic [1:0]  nnz;
      logic        ovf;
      logic        last;
   } pkt_t;

   typedef struct packed {
      tab2_t d;
      tab2_t r;
      tab2_t c;
   } fetch_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   tab4_t       in_data, in_row_table, in_col_table;
   logic [15:0] in_num_rows;
   logic        in_valid0, in_valid1, out_ready;

   logic        in_ready0, in_ready1;
   tab4_t       fdat0, frow0, fcol0, fdat1, frow1, fcol1;
   logic [15:0] fidx0, fidx1;
   fetch_t      f0, f1;
   tab2_t       out_data0, out_row0, out_col0, out_data1, out_row1, out_col1;
   logic [15:0] out_idx0, out_idx1;
   logic [1:0]  out_nnz0, out_nnz1;
   logic        out_ovf0, out_ovf1, out_last0, out_last1;
   logic        out_valid0, out_valid1, busy0, busy1;

   int   checks = 0;
   int   errors = 0;
   pkt_t sb0[$];
   pkt_t sb1[$];
   pkt_t e0, a0, e1, a1;

   always #5 clk = ~clk;

   // Reference fetcher: first FETCH_SIZE entries of the requested row, in tile order.
   function automatic fetch_t fetch_model(input tab4_t d, input tab4_t r, input tab4_t c,
                                          input logic [15:0] idx);
      fetch_t f;
      int     k;
      f = '0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         if (r[i] == idx && k < 2) begin
            f.d[k] = d[i];
            f.r[k] = r[i];
            f.c[k] = c[i];
            k++;
         end
      end
      return f;
   endfunction

   assign f0 = fetch_model(fdat0, frow0, fcol0, fidx0);
   assign f1 = fetch_model(fdat1, frow1, fcol1, fidx1);

   coo_row_scheduler #(
      .IN_SIZE(4), .FETCH_SIZE(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .SKIP_EMPTY(0)
   ) dut0 (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_row_table(in_row_table), .in_col_table(in_col_table),
      .in_num_rows(in_num_rows), .in_valid(in_valid0), .in_ready(in_ready0),
      .fetch_data(fdat0), .fetch_row_table(frow0), .fetch_col_table(fcol0),
      .fetch_row_index(fidx0),
      .fetched_data(f0.d), .fetched_row_table(f0.r), .fetched_col_table(f0.c),
      .out_data(out_data0), .out_row_table(out_row0), .out_col_table(out_col0),
      .out_row_index(out_idx0), .out_nnz(out_nnz0), .out_overflow(out_ovf0),
      .out_last(out_last0), .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0)
   );

   coo_row_scheduler #(
      .IN_SIZE(4), .FETCH_SIZE(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .SKIP_EMPTY(1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_row_table(in_row_table), .in_col_table(in_col_table),
      .in_num_rows(in_num_rows), .in_valid(in_valid1), .in_ready(in_ready1),
      .fetch_data(fdat1), .fetch_row_table(frow1), .fetch_col_table(fcol1),
      .fetch_row_index(fidx1),
      .fetched_data(f1.d), .fetched_row_table(f1.r), .fetched_col_table(f1.c),
      .out_data(out_data1), .out_row_table(out_row1), .out_col_table(out_col1),
      .out_row_index(out_idx1), .out_nnz(out_nnz1), .out_overflow(out_ovf1),
      .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1)
   );

   function automatic tab4_t pack4(input logic [15:0] v0, v1, v2, v3);
      tab4_t t;
      t[0] = v0; t[1] = v1; t[2] = v2; t[3] = v3;
      return t;
   endfunction

   function automatic tab2_t pack2(input logic [15:0] v0, v1);
      tab2_t t;
      t[0] = v0; t[1] = v1;
      return t;
   endfunction

   function automatic pkt_t mk_pkt(input logic [15:0] idx, d0, d1, c0, c1,
                                   input logic [1:0] nnz, input logic ovf, last);
      pkt_t p;
      p.d    = pack2(d0, d1);
      p.c    = pack2(c0, c1);
      p.r    = pack2((nnz > 0) ? idx : 16'd0, (nnz > 1) ? idx : 16'd0);
      p.idx  = idx;
      p.nnz  = nnz;
      p.ovf  = ovf;
      p.last = last;
      return p;
   endfunction

   task automatic push_basic();
      sb0.push_back(mk_pkt(16'd0, 16'd10, 16'd30, 16'd3, 16'd0, 2'd2, 1'b0, 1'b0));
      sb0.push_back(mk_pkt(16'd1, 16'd20, 16'd0, 16'd1, 16'd0, 2'd1, 1'b0, 1'b0));
      sb0.push_back(mk_pkt(16'd2, 16'd40, 16'd0, 16'd2, 16'd0, 2'd1, 1'b0, 1'b1));
   endtask

   task automatic push_ovf();
      sb0.push_back(mk_pkt(16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 2'd2, 1'b1, 1'b0));
      sb0.push_back(mk_pkt(16'd1, 16'd4, 16'd0, 16'd8, 16'd0, 2'd1, 1'b0, 1'b1));
   endtask

   // Drives a tile and holds in_valid until the selected instance accepts it.
   task automatic send_tile(input tab4_t d, input tab4_t r, input tab4_t c,
                            input logic [15:0] nr, input bit to_skip);
      int cyc = 0;
      in_data      = d;
      in_row_table = r;
      in_col_table = c;
      in_num_rows  = nr;
      if (to_skip) in_valid1 = 1'b1;
      else in_valid0 = 1'b1;
      while (((to_skip ? in_ready1 : in_ready0) !== 1'b1) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 100) begin
         checks++; errors++;
         $display("FAIL send_tile: in_ready never rose within 100 cycles, required 1");
      end
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
         checks++;
         a0 = '{d: out_data0, c: out_col0, r: out_row0, idx: out_idx0, nnz: out_nnz0,
                ovf: out_ovf0, last: out_last0};
         if (sb0.size() == 0) begin
            errors++;
            $display("FAIL pkt0_unexpected: got row %0d, required no packet", out_idx0);
         end else begin
            e0 = sb0.pop_front();
            if (a0 !== e0) begin
               errors++;
               $display("FAIL pkt0_row%0d: got d=%h c=%h r=%h idx=%0d nnz=%0d ovf=%b last=%b, required d=%h c=%h r=%h idx=%0d nnz=%0d ovf=%b last=%b",
                        e0.idx, a0.d, a0.c, a0.r, a0.idx, a0.nnz, a0.ovf, a0.last,
                        e0.d, e0.c, e0.r, e0.idx, e0.nnz, e0.ovf, e0.last);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid1 === 1'b1 && out_ready === 1'b1) begin
         checks++;
         a1 = '{d: out_data1, c: out_col1, r: out_row1, idx: out_idx1, nnz: out_nnz1,
                ovf: out_ovf1, last: out_last1};
         if (sb1.size() == 0) begin
            errors++;
            $display("FAIL pkt1_unexpected: got row %0d, required no packet", out_idx1);
         end else begin
            e1 = sb1.pop_front();
            if (a1 !== e1) begin
               errors++;
               $display("FAIL pkt1_row%0d: got d=%h c=%h r=%h idx=%0d nnz=%0d ovf=%b last=%b, required d=%h c=%h r=%h idx=%0d nnz=%0d ovf=%b last=%b",
                        e1.idx, a1.d, a1.c, a1.r, a1.idx, a1.nnz, a1.ovf, a1.last,
                        e1.d, e1.c, e1.r, e1.idx, e1.nnz, e1.ovf, e1.last);
            end
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1} !== 6'b100100) begin
         errors++;
         $display("FAIL reset_handshake: got rdy/vld/busy=%b%b%b %b%b%b, required 100 100",
                  in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1);
      end
      checks++;
      if (fidx0 !== 16'd0 || fdat0 !== '0 || frow0 !== '0 || fcol0 !== '0) begin
         errors++;
         $display("FAIL reset_fetch: got idx=%0d data=%h rows=%h cols=%h, required all 0",
                  fidx0, fdat0, frow0, fcol0);
      end
      checks++;
      if ({out_data0, out_row0, out_col0, out_idx0, out_nnz0, out_ovf0, out_last0} !== '0) begin
         errors++;
         $display("FAIL reset_out: got data=%h idx=%0d nnz=%0d ovf=%b last=%b, required 0",
                  out_data0, out_idx0, out_nnz0, out_ovf0, out_last0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b busy=%b, required 1 0", in_ready0, busy0);
      end
   endtask

   task automatic test_basic();
      push_basic();
      in_data      = pack4(16'd10, 16'd20, 16'd30, 16'd40);
      in_row_table = pack4(16'd0, 16'd1, 16'd0, 16'd2);
      in_col_table = pack4(16'd3, 16'd1, 16'd0, 16'd2);
      in_num_rows  = 16'd3;
      in_valid0    = 1'b1;
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready: got in_ready=%b, required 1", in_ready0);
      end
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      checks++;
      if (out_valid0 !== 1'b0 || busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_t1: got vld=%b busy=%b rdy=%b, required 0 1 0",
                  out_valid0, busy0, in_ready0);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency: got out_valid=%b at T+2, required 1", out_valid0);
      end
      for (int c = 0; c < 60 && sb0.size() != 0; c++) @(posedge clk);
      #1;
      checks++;
      if (sb0.size() != 0 || busy0 !== 1'b0 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL basic_drain: got pending=%0d busy=%b rdy=%b, required 0 0 1",
                  sb0.size(), busy0, in_ready0);
      end
   endtask

   task automatic test_backpressure();
      bit found = 1'b0;
      push_basic();
      send_tile(pack4(16'd10, 16'd20, 16'd30, 16'd40), pack4(16'd0, 16'd1, 16'd0, 16'd2),
                pack4(16'd3, 16'd1, 16'd0, 16'd2), 16'd3, 1'b0);
      for (int c = 0; c < 20 && !found; c++) begin
         @(posedge clk); #1;
         if (out_valid0 === 1'b1 && out_idx0 === 16'd1) found = 1'b1;
      end
      out_ready = 1'b0;
      if (!found) begin
         checks++; errors++;
         $display("FAIL bp_wait: row 1 never offered within 20 cycles, required offer");
      end
      for (int s = 0; s < 5; s++) begin
         checks++;
         if (out_valid0 !== 1'b1 || busy0 !== 1'b1 || out_idx0 !== 16'd1 ||
             out_data0 !== pack2(16'd20, 16'd0) || out_nnz0 !== 2'd1 || out_last0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall%0d: got vld=%b busy=%b idx=%0d data=%h nnz=%0d last=%b, required 1 1 1 %h 1 0",
                     s, out_valid0, busy0, out_idx0, out_data0, out_nnz0, out_last0,
                     pack2(16'd20, 16'd0));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 60 && sb0.size() != 0; c++) @(posedge clk);
      #1;
      checks++;
      if (sb0.size() != 0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got pending=%0d busy=%b, required 0 0", sb0.size(), busy0);
      end
   endtask

   task automatic test_overflow();
      push_ovf();
      send_tile(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd0, 16'd0, 16'd0, 16'd1),
                pack4(16'd5, 16'd6, 16'd7, 16'd8), 16'd2, 1'b0);
      for (int c = 0; c < 60 && sb0.size() != 0; c++) @(posedge clk);
      #1;
      checks++;
      if (sb0.size() != 0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drain: got pending=%0d busy=%b, required 0 0", sb0.size(), busy0);
      end
   endtask

   task automatic test_skip_empty();
      sb1.push_back(mk_pkt(16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 2'd1, 1'b0, 1'b0));
      sb1.push_back(mk_pkt(16'd2, 16'd2, 16'd3, 16'd1, 16'd2, 2'd2, 1'b1, 1'b0));
      sb1.push_back(mk_pkt(16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1));
      send_tile(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd0, 16'd2, 16'd2, 16'd2),
                pack4(16'd0, 16'd1, 16'd2, 16'd3), 16'd4, 1'b1);
      for (int c = 0; c < 60 && sb1.size() != 0; c++) @(posedge clk);
      #1;
      checks++;
      if (sb1.size() != 0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL skip_drain: got pending=%0d busy=%b, required 0 0", sb1.size(), busy1);
      end
   endtask

   task automatic test_zero_rows();
      send_tile(pack4(16'd9, 16'd9, 16'd9, 16'd9), pack4(16'd0, 16'd0, 16'd0, 16'd0),
                pack4(16'd0, 16'd0, 16'd0, 16'd0), 16'd0, 1'b0);
      for (int s = 0; s < 4; s++) begin
         checks++;
         if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL zero_rows%0d: got rdy=%b busy=%b vld=%b, required 1 0 0",
                     s, in_ready0, busy0, out_valid0);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      sb0.push_back(mk_pkt(16'd0, 16'd10, 16'd30, 16'd3, 16'd0, 2'd2, 1'b0, 1'b0));
      send_tile(pack4(16'd10, 16'd20, 16'd30, 16'd40), pack4(16'd0, 16'd1, 16'd0, 16'd2),
                pack4(16'd3, 16'd1, 16'd0, 16'd2), 16'd3, 1'b0);
      for (int c = 0; c < 20 && !found; c++) begin
         @(posedge clk); #1;
         if (out_valid0 === 1'b1 && out_idx0 === 16'd1) found = 1'b1;
      end
      out_ready = 1'b0;
      if (!found) begin
         checks++; errors++;
         $display("FAIL rstmid_wait: row 1 never offered within 20 cycles, required offer");
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0 || fidx0 !== 16'd0 ||
          out_idx0 !== 16'd0 || sb0.size() != 0) begin
         errors++;
         $display("FAIL rstmid_state: got vld=%b rdy=%b busy=%b fidx=%0d oidx=%0d pending=%0d, required 0 1 0 0 0 0",
                  out_valid0, in_ready0, busy0, fidx0, out_idx0, sb0.size());
      end
      rst = 1'b0;
      out_ready = 1'b1;
      push_ovf();
      send_tile(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd0, 16'd0, 16'd0, 16'd1),
                pack4(16'd5, 16'd6, 16'd7, 16'd8), 16'd2, 1'b0);
      for (int c = 0; c < 60 && sb0.size() != 0; c++) @(posedge clk);
      #1;
      checks++;
      if (sb0.size() != 0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_drain: got pending=%0d busy=%b, required 0 0", sb0.size(), busy0);
      end
   endtask

   task automatic test_back_to_back();
      push_basic();
      push_ovf();
      send_tile(pack4(16'd10, 16'd20, 16'd30, 16'd40), pack4(16'd0, 16'd1, 16'd0, 16'd2),
                pack4(16'd3, 16'd1, 16'd0, 16'd2), 16'd3, 1'b0);
      send_tile(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd0, 16'd0, 16'd0, 16'd1),
                pack4(16'd5, 16'd6, 16'd7, 16'd8), 16'd2, 1'b0);
      // The second tile may only be taken once every packet of the first has gone.
      checks++;
      if (sb0.size() != 2) begin
         errors++;
         $display("FAIL b2b_order: got pending=%0d at second accept, required 2", sb0.size());
      end
      for (int c = 0; c < 60 && sb0.size() != 0; c++) @(posedge clk);
      #1;
      checks++;
      if (sb0.size() != 0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got pending=%0d busy=%b, required 0 0", sb0.size(), busy0);
      end
   endtask

   initial begin
      in_data      = '0;
      in_row_table = '0;
      in_col_table = '0;
      in_num_rows  = '0;
      in_valid0    = 1'b0;
      in_valid1    = 1'b0;
      out_ready    = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_skip_empty();
      test_zero_rows();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/coo_row_scheduler.md
Name: coo_row_scheduler

Overview:
- Sequencer for the combinational COO row-fetch datapath.
- Accepts one COO matrix tile with a valid/ready handshake and holds it in registers.
- Drives the fetch row index from 0 to num_rows-1 and registers each fetched row.
- Streams each row downstream as a COO row packet with a valid/ready handshake, plus a per-row nonzero count, an overflow flag and a last-row flag.

Parameters:
- IN_SIZE, 4: number of COO entries in an input tile.
- FETCH_SIZE, 2: number of entries in each emitted row packet.
- DATA_WIDTH, 16: width of a data element.
- ADDR_WIDTH, 16: width of row and column indices, num_rows and the row counter.
- SKIP_EMPTY, 0: when 1, rows with zero nonzeros are not emitted, except the final row.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  DATA_WIDTH x IN_SIZE  tile values.
- in_row_table  in  ADDR_WIDTH x IN_SIZE  tile row indices.
- in_col_table  in  ADDR_WIDTH x IN_SIZE  tile column indices.
- in_num_rows  in  ADDR_WIDTH  number of rows to sequence.
- in_valid  in  1  tile valid.
- in_ready  out  1  tile accepted when in_valid && in_ready.
- fetch_data  out  DATA_WIDTH x IN_SIZE  latched tile values, to the fetcher.
- fetch_row_table  out  ADDR_WIDTH x IN_SIZE  latched row indices, to the fetcher.
- fetch_col_table  out  ADDR_WIDTH x IN_SIZE  latched column indices, to the fetcher.
- fetch_row_index  out  ADDR_WIDTH  current row counter, to the fetcher.
- fetched_data  in  DATA_WIDTH x FETCH_SIZE  fetcher result values.
- fetched_row_table  in  ADDR_WIDTH x FETCH_SIZE  fetcher result row indices.
- fetched_col_table  in  ADDR_WIDTH x FETCH_SIZE  fetcher result column indices.
- out_data  out  DATA_WIDTH x FETCH_SIZE  emitted row values.
- out_row_table  out  ADDR_WIDTH x FETCH_SIZE  emitted row indices.
- out_col_table  out  ADDR_WIDTH x FETCH_SIZE  emitted column indices.
- out_row_index  out  ADDR_WIDTH  index of the emitted row.
- out_nnz  out  $clog2(FETCH_SIZE+1)  min(true row count, FETCH_SIZE).
- out_overflow  out  1  true row count exceeded FETCH_SIZE, so entries were dropped.
- out_last  out  1  emitted row is row num_rows-1.
- out_valid  out  1  row packet valid.
- out_ready  in  1  downstream ready.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Single clock domain; all state updates on posedge clk.
- Reset:
  - rst is synchronous and active-high.
  - On reset: state goes to IDLE; in_ready=1; out_valid=0; busy=0; row counter=0.
  - All out_* registers and all latched tile registers clear to 0; fetch_row_index=0.
  - Reset asserted mid-tile aborts the tile with no further output; the partial tile is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid: latch the tile and num_rows, clear the row counter, go to FETCH.
  - If in_num_rows==0: the tile is accepted and dropped, no packet is produced, and the state stays IDLE.
- FETCH (1 cycle):
  - in_ready=0.
  - fetch_row_index drives the row counter.
  - The true count is the number of latched in_row_table entries equal to the counter, computed internally with width $clog2(IN_SIZE+1).
  - At the end of the cycle, register: fetched_* into out_*; counter into out_row_index; min(count, FETCH_SIZE) into out_nnz; (count > FETCH_SIZE) into out_overflow; (counter == num_rows-1) into out_last.
  - If SKIP_EMPTY=1, count==0 and not the last row: increment the counter and stay in FETCH, with no emission.
  - Otherwise go to EMIT.
- EMIT:
  - out_valid=1. out_* stay stable while out_valid && !out_ready.
  - On out_ready:
    - if out_last, go to IDLE with out_valid=0;
    - else increment the counter and go to FETCH, with out_valid=0 during FETCH.
- Timing:
  - Latency from acceptance cycle T to first out_valid is T+2.
  - Peak throughput is one row per 2 cycles.
  - A new tile cannot be accepted in the cycle out_last handshakes; it is accepted no earlier than the following cycle.
- Entries whose row index is >= num_rows are never fetched and are silently ignored.
- The row counter never wraps, because the last-row check terminates the tile first.

Test Plan:
- IN_SIZE=4, FETCH_SIZE=2, SKIP_EMPTY=0; tile rows{0,1,0,2}, data{10,20,30,40}, cols{3,1,0,2}, num_rows=3, out_ready=1 → three packets:
  - row0: data{10,30}, cols{3,0}, nnz=2;
  - row1: data{20,0}, nnz=1;
  - row2: data{40,0}, nnz=1, last=1;
  - first out_valid 2 cycles after acceptance.
- Same tile, out_ready held low for 5 cycles on row1 → out_* stable throughout, no row skipped, busy=1 until row2 handshakes.
- Rows{0,0,0,1}, data{1,2,3,4}, num_rows=2 → row0: data{1,2}, nnz=2, overflow=1; row1: data{4,0}, overflow=0, last=1.
- SKIP_EMPTY=1, rows{0,2,2,2}, num_rows=4 → packets for rows 0, 2 and 3 only; row3: nnz=0, last=1.
- num_rows=0 → tile accepted, no out_valid, in_ready stays 1.
- rst pulsed while in EMIT on row1 → next cycle state is IDLE, out_valid=0, in_ready=1; a new tile then runs correctly from row0.
